// File: rtl/flash_pkg.sv
// Shared constants and types for the SPI-flash responder.
package flash_pkg;

  // Supported M25P16 opcodes.
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_BE   = 8'hC7;

  // Status register bit positions.
  localparam int unsigned STAT_WIP = 0;
  localparam int unsigned STAT_WEL = 1;

  // One-hot frame state.
  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StCmd    = 4'b0010,
    StResp   = 4'b0100,
    StIgnore = 4'b1000
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_WEL] = wel;
    s[STAT_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/flash_spi_resp_if.sv
// Four-wire SPI bus between a flash master and the responder.
interface flash_spi_resp_if;
  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output cs_n, output sck, output mosi, input miso);
  modport slave  (input cs_n, input sck, input mosi, output miso);
endinterface

// File: rtl/spi_in_sync.sv
// Synchronizes the SPI inputs into sys_clk and detects sck/cs edges.
module spi_in_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output logic cs_fall,
  output logic cs_rise,
  output logic sck_rise,
  output logic mosi_s
);

  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  // Two-stage synchronizers plus a third stage on cs/sck for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], cs_n};
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/flash_spi_resp.sv
// SPI-flash responder modelling WREN/WRDI/RDSR/RDID/BE with WEL/WIP tracking.
module flash_spi_resp
  import flash_pkg::*;
#(
  parameter int unsigned BE_BUSY_CYC = 1000,
  parameter logic [7:0]  ID_MFR      = 8'h20,
  parameter logic [7:0]  ID_TYPE     = 8'h20,
  parameter logic [7:0]  ID_CAP      = 8'h15
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  flash_spi_resp_if.slave  spi,
  output logic             wel,
  output logic             wip,
  output logic             cmd_vld,
  output logic [7:0]       cmd_code,
  output logic             erase_done
);

  localparam int unsigned BusyW = (BE_BUSY_CYC > 2) ? $clog2(BE_BUSY_CYC) : 1;
  localparam logic [BusyW-1:0] BusyLast = BusyW'(BE_BUSY_CYC - 1);

  logic cs_fall, cs_rise, sck_rise, mosi_s;

  spi_in_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cs_n      (spi.cs_n),
    .sck       (spi.sck),
    .mosi      (spi.mosi),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sck_rise  (sck_rise),
    .mosi_s    (mosi_s)
  );

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic             miso_q, miso_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic [7:0]       cmd_code_q, cmd_code_d;
  logic             wel_q, wel_d;
  logic             wip_q, wip_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic             erase_done_q, erase_done_d;

  logic [7:0] rx_byte;
  logic       bit_last;
  logic       frame_exact;

  // Byte sent at response position idx; RDID pads with zeros after the ID.
  function automatic logic [7:0] resp_byte(input logic [7:0] code, input logic [1:0] idx,
                                           input logic wel_v, input logic wip_v);
    logic [7:0] b;
    b = 8'h00;
    if (code == CMD_RDSR) begin
      b = status_byte(wel_v, wip_v);
    end else if (code == CMD_RDID) begin
      unique case (idx)
        2'd0:    b = ID_MFR;
        2'd1:    b = ID_TYPE;
        2'd2:    b = ID_CAP;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 7'd0;
      tx_q         <= 8'd0;
      miso_q       <= 1'b0;
      cmd_vld_q    <= 1'b0;
      cmd_code_q   <= 8'h00;
      wel_q        <= 1'b0;
      wip_q        <= 1'b0;
      busy_cnt_q   <= '0;
      erase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      cmd_vld_q    <= cmd_vld_d;
      cmd_code_q   <= cmd_code_d;
      wel_q        <= wel_d;
      wip_q        <= wip_d;
      busy_cnt_q   <= busy_cnt_d;
      erase_done_q <= erase_done_d;
    end
  end

  assign rx_byte     = {shift_q, mosi_s};
  assign bit_last    = (bit_cnt_q == 3'd7);
  assign frame_exact = (byte_cnt_q == 2'd1) && (bit_cnt_q == 3'd0);

  // Frame FSM, response shifter, command execution and erase timer.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    cmd_vld_d    = 1'b0;
    cmd_code_d   = cmd_code_q;
    wel_d        = wel_q;
    wip_d        = wip_q;
    busy_cnt_d   = busy_cnt_q;
    erase_done_d = 1'b0;

    // Bits are counted in every active state so over-long frames are recognised.
    if (sck_rise && (state_q != StIdle)) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_last && (byte_cnt_q != 2'd3)) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StCmd;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 2'd0;
          shift_d    = 7'd0;
          tx_d       = 8'd0;
          miso_d     = 1'b0;
        end
      end
      StCmd: begin
        if (sck_rise) begin
          shift_d = rx_byte[6:0];
          if (bit_last) begin
            cmd_vld_d  = 1'b1;
            cmd_code_d = rx_byte;
            if ((rx_byte == CMD_RDSR) || ((rx_byte == CMD_RDID) && !wip_q)) begin
              state_d        = StResp;
              {miso_d, tx_d} = {resp_byte(rx_byte, 2'd0, wel_q, wip_q), 1'b0};
            end else begin
              state_d = StIgnore;
            end
          end
        end
      end
      StResp: begin
        if (sck_rise) begin
          // byte_cnt_q at a boundary equals the index of the byte about to start.
          if (bit_last) begin
            {miso_d, tx_d} = {resp_byte(cmd_code_q, byte_cnt_q, wel_q, wip_q), 1'b0};
          end else begin
            {miso_d, tx_d} = {tx_q, 1'b0};
          end
        end
      end
      StIgnore: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        miso_d  = 1'b0;
      end
    endcase

    if (wip_q) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
      if (busy_cnt_q == BusyLast) begin
        wip_d        = 1'b0;
        wel_d        = 1'b0;
        erase_done_d = 1'b1;
        busy_cnt_d   = '0;
      end
    end

    // A write-class command only takes effect if the frame was exactly one byte.
    if (cs_rise) begin
      state_d = StIdle;
      miso_d  = 1'b0;
      if ((state_q != StIdle) && frame_exact && !wip_q) begin
        if (cmd_code_q == CMD_WREN) begin
          wel_d = 1'b1;
        end else if (cmd_code_q == CMD_WRDI) begin
          wel_d = 1'b0;
        end else if ((cmd_code_q == CMD_BE) && wel_q) begin
          wip_d      = 1'b1;
          busy_cnt_d = '0;
        end
      end
    end
  end

  assign spi.miso   = miso_q & (state_q == StResp);
  assign wel        = wel_q;
  assign wip        = wip_q;
  assign cmd_vld    = cmd_vld_q;
  assign cmd_code   = cmd_code_q;
  assign erase_done = erase_done_q;

endmodule

// File: tb/tb_flash_spi_resp.sv
// Randomized bench for flash_spi_resp against a transaction-level flash model.
module tb_flash_spi_resp;

  localparam int unsigned BeCyc = 1000;
  localparam logic [7:0] IdMfr  = 8'h20;
  localparam logic [7:0] IdType = 8'h20;
  localparam logic [7:0] IdCap  = 8'h15;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       wel, wip, cmd_vld, erase_done;
  logic [7:0] cmd_code;

  flash_spi_resp_if spi_if ();

  flash_spi_resp #(
    .BE_BUSY_CYC (BeCyc),
    .ID_MFR      (IdMfr),
    .ID_TYPE     (IdType),
    .ID_CAP      (IdCap)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .spi        (spi_if),
    .wel        (wel),
    .wip        (wip),
    .cmd_vld    (cmd_vld),
    .cmd_code   (cmd_code),
    .erase_done (erase_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference flash state.
  logic model_wel  = 1'b0;
  logic model_busy = 1'b0;
  int   erase_start = 0;
  int   exp_done    = 0;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Observers: pulse counts and length of each WIP window.
  int   vld_cnt  = 0;
  int   done_cnt = 0;
  int   wip_len  = 0;
  logic wip_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      wip_len  <= 0;
      wip_prev <= 1'b0;
    end else begin
      if (cmd_vld) vld_cnt <= vld_cnt + 1;
      if (erase_done) done_cnt <= done_cnt + 1;
      if (wip) begin
        wip_len <= wip_len + 1;
      end else if (wip_prev) begin
        check_eq("busy_len", wip_len, BeCyc);
        check_eq("done_at_wip_fall", erase_done, 1'b1);
        wip_len <= 0;
      end
      wip_prev <= wip;
    end
  end

  function automatic logic [7:0] exp_resp(input logic [7:0] cmd, input int k);
    if (cmd == 8'h05) return {6'b0, model_wel, model_busy};
    if (cmd == 8'h9F && !model_busy) begin
      if (k == 0) return IdMfr;
      if (k == 1) return IdType;
      if (k == 2) return IdCap;
    end
    return 8'h00;
  endfunction

  task automatic finish_erase();
    if (model_busy) begin
      while (cyc < erase_start + int'(BeCyc) + 10) @(posedge sys_clk);
      model_busy = 1'b0;
      model_wel  = 1'b0;
      exp_done++;
    end
  endtask

  // Keep frames clear of the erase end so the model's view of WIP is unambiguous.
  task automatic guard_busy();
    if (model_busy && (cyc + 300 > erase_start + int'(BeCyc))) finish_erase();
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int nresp);
    int         total;
    int         vld0;
    logic [7:0] rx [4];
    logic [7:0] exp_b [4];
    guard_busy();
    total = nbits + 8 * nresp;
    vld0  = vld_cnt;
    for (int k = 0; k < 4; k++) begin
      rx[k]    = 8'h00;
      exp_b[k] = exp_resp(cmd, k);
    end
    @(negedge sys_clk);
    spi_if.cs_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < total; i++) begin
      spi_if.mosi = (i < 8) ? cmd[7 - i] : 1'($urandom_range(0, 1));
      repeat (2) @(negedge sys_clk);
      if (i >= 8) rx[(i - 8) / 8][7 - ((i - 8) % 8)] = spi_if.miso;
      spi_if.sck = 1'b1;
      repeat (2) @(negedge sys_clk);
      spi_if.sck = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
    if (nbits >= 8) check_eq("cmd_code", cmd_code, cmd);
    check_eq("cmd_vld_count", vld_cnt - vld0, (nbits >= 8) ? 1 : 0);
    for (int k = 0; k < nresp; k++) check_eq("resp_byte", rx[k], exp_b[k]);
    spi_if.cs_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    if (total == 8 && !model_busy) begin
      if (cmd == 8'h06) model_wel = 1'b1;
      else if (cmd == 8'h04) model_wel = 1'b0;
      else if (cmd == 8'hC7 && model_wel) begin
        model_busy  = 1'b1;
        erase_start = cyc;
      end
    end
    check_eq("wel", wel, model_wel);
    check_eq("wip", wip, model_busy);
    check_eq("miso_idle", spi_if.miso, 1'b0);
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc;
    int         r, nb, nr;
    sys_rst_n   = 1'b0;
    spi_if.cs_n = 1'b1;
    spi_if.sck  = 1'b0;
    spi_if.mosi = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_miso", spi_if.miso, 1'b0);
    check_eq("rst_wel", wel, 1'b0);
    check_eq("rst_wip", wip, 1'b0);
    check_eq("rst_cmd_vld", cmd_vld, 1'b0);
    check_eq("rst_cmd_code", cmd_code, 8'h00);
    check_eq("rst_erase_done", erase_done, 1'b0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Directed walk through the main scenarios.
    spi_frame(8'h06, 8, 0);
    spi_frame(8'hC7, 8, 0);
    spi_frame(8'h05, 8, 3);
    finish_erase();
    spi_frame(8'h05, 8, 1);
    spi_frame(8'h9F, 8, 4);
    spi_frame(8'h06, 8, 0);
    spi_frame(8'hC7, 8, 0);
    spi_frame(8'h9F, 8, 4);
    spi_frame(8'h06, 8, 0);
    finish_erase();
    spi_frame(8'hC7, 8, 0);
    spi_frame(8'h06, 5, 0);
    spi_frame(8'h06, 8, 1);

    // Randomized command mix.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    rc = 8'h06;
        2:       rc = 8'h04;
        3:       rc = 8'h05;
        4:       rc = 8'h9F;
        5, 6:    rc = 8'hC7;
        default: rc = 8'($urandom);
      endcase
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      nr = 0;
      if (nb == 8) begin
        if (rc == 8'h05 || rc == 8'h9F) nr = $urandom_range(1, 3);
        else if ($urandom_range(0, 3) == 0) nr = $urandom_range(1, 3);
      end
      spi_frame(rc, nb, nr);
    end
    finish_erase();
    check_eq("erase_done_count", done_cnt, exp_done);

    // Reset in the middle of an erase aborts it silently.
    spi_frame(8'h06, 8, 0);
    spi_frame(8'hC7, 8, 0);
    repeat (200) @(posedge sys_clk);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    check_eq("abort_wip", wip, 1'b0);
    check_eq("abort_wel", wel, 1'b0);
    check_eq("abort_miso", spi_if.miso, 1'b0);
    model_busy = 1'b0;
    model_wel  = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (1100) @(posedge sys_clk);
    check_eq("abort_no_done", done_cnt, exp_done);
    spi_frame(8'h05, 8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
